hsys_memory_arbiter: RTL and testbench
======================================

HSYS_MEMORY_ARBITER -- requirements
Module: hsys_memory_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, word address width; DATA_W, default 64, data width; BE_W, default 8, byteenable width (DATA_W/8).
REQ-002 clk  input  1  sole clock; all state SHALL be on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mN_address  input  ADDR_W  requester N word address (N = 0, 1 for every mN_* port).
REQ-005 mN_byteenable  input  BE_W  requester N byte lanes.
REQ-006 mN_read / mN_write  input  1 each  requester N read or write request.
REQ-007 mN_writedata  input  DATA_W  requester N write data.
REQ-008 mN_waitrequest  output  1  high = requester N request not accepted this cycle.
REQ-009 mN_readdata  output  DATA_W  requester N read data.
REQ-010 mN_readdatavalid  output  1  requester N read data valid.
REQ-011 mem_address  output  ADDR_W  memory word address.
REQ-012 mem_byteenable  output  BE_W  memory byte lanes.
REQ-013 mem_chipselect / mem_write  output  1 each  memory select and write strobe.
REQ-014 mem_writedata  output  DATA_W  memory write data.
REQ-015 mem_clken  output  1  memory clock enable.
REQ-016 mem_readdata  input  DATA_W  memory read data, valid exactly 1 cycle after the read address is presented.

Function
REQ-017 Requester N request SHALL be req_N = mN_read | mN_write; if both are high, the access SHALL be a write.
REQ-018 Arbitration SHALL be combinational, one grant per cycle, round-robin:
- only one req_N high: that requester is granted;
- both high: the requester not granted most recently wins.
REQ-019 A 1-bit last-grant register SHALL update on every grant and hold when there is no grant; reset value 1, so m0 wins the first contention.
REQ-020 Grant signals:
- mN_waitrequest = ~grant_N, so it is high when idle or losing arbitration;
- the granted access SHALL complete in that cycle.
REQ-021 Memory port SHALL be a combinational mux of the granted requester's address, byteenable and writedata:
- mem_chipselect = any grant;
- mem_write = granted request is a write;
- with no grant: mem_chipselect = 0, mem_write = 0, other mem_* outputs don't-care.
REQ-022 mem_clken SHALL be constant 1.
REQ-023 Read return:
- a granted read SHALL register a valid bit and requester tag;
- next cycle, mN_readdatavalid = 1 only for the tagged requester;
- mN_readdata = mem_readdata for both requesters, qualified by readdatavalid.
REQ-024 Throughput: one access per cycle. Back-to-back reads from either or both requesters SHALL return in grant order, 1-cycle latency each, with no bubbles.
REQ-025 A write granted in cycle T followed by a read of the same address granted in T+1 SHALL return the written data (memory write-then-read ordering preserved).
REQ-026 Writes SHALL produce no readdatavalid.
REQ-027 With continuous contention, grants SHALL strictly alternate, so neither requester waits more than 1 cycle.

Reset
REQ-028 While reset_n = 0:
- last-grant register = 1;
- read valid/tag registers = 0;
- mN_readdatavalid = 0;
- mN_waitrequest = 1;
- mem_chipselect = 0; mem_write = 0.
REQ-029 Reset asserted mid-operation SHALL discard any read in flight: no readdatavalid after reset_n rises.
REQ-030 The first grant SHALL occur no earlier than the first rising edge with reset_n = 1.

Structure
REQ-031 ADDR_W/DATA_W/BE_W defaults and the requester-index encoding (0 = m0, 1 = m1) SHALL live in the shared HSys package.
REQ-032 The round-robin grant logic SHALL be one sub-module, hsys_rr_arbiter2: inputs req[1:0], advance, clk, reset_n; output grant[1:0].
REQ-033 The read-return pipeline stage SHALL stay in the top module.

Verification
REQ-034 Directed scenarios, driven against a behavioural 1024x64 single-port memory model with 1-cycle read latency:
- Single write: m0 writes addr 0x005, data 0x0123456789ABCDEF, be 0xFF; m0 then reads 0x005 -> m0_waitrequest low both cycles, m0_readdatavalid one cycle after the read, data 0x0123456789ABCDEF; m1_readdatavalid stays 0.
- Byte lanes: m1 writes 0xFFFF_FFFF_FFFF_FFFF to 0x3FF with be 0xFF, then writes 0 with be 0x0F, then reads 0x3FF -> m1 gets 0xFFFFFFFF00000000.
- Contention: m0 and m1 both read continuously for 8 cycles from reset -> grants m0,m1,m0,... and 4 readdatavalid pulses per requester, each 1 cycle after its grant.
- Write-then-read across requesters: m0 writes 0xAAAA... to 0x010 in cycle T; m1 reads 0x010, granted T+1 -> m1 receives 0xAAAAAAAAAAAAAAAA.
- Reset mid-read: m0 read granted, reset_n pulled low before the next edge -> m0_readdatavalid never asserts; after release, m0 wins the first contention.
- Idle: no requests for 5 cycles -> mem_chipselect = 0, both waitrequests = 1, last-grant register unchanged.

Source files
------------

// File: rtl/hsys_memory_arbiter_pkg.sv
// Shared HSys definitions for the two-requester memory arbiter.
package hsys_memory_arbiter_pkg;

  // Default geometry: 1024 x 64-bit words, one byteenable bit per byte lane.
  localparam int unsigned DefaultAddrW = 10;
  localparam int unsigned DefaultDataW = 64;
  localparam int unsigned DefaultBeW   = DefaultDataW / 8;

  // Requester index encoding, also used as the read-return tag.
  typedef enum logic {
    ReqM0 = 1'b0,
    ReqM1 = 1'b1
  } req_idx_e;

  // Map a one-hot (or zero) grant vector onto a requester index.
  function automatic req_idx_e grant_to_idx(input logic [1:0] grant);
    return (grant == 2'b10) ? ReqM1 : ReqM0;
  endfunction

endpackage

// File: rtl/hsys_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, 1-bit last-grant history.
module hsys_rr_arbiter2
  import hsys_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_idx_e last_q, last_d;

  // Grant a lone requester outright; on contention the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == ReqM1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // History follows every grant and holds across idle cycles.
  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00)) begin
      last_d = grant_to_idx(grant);
    end
  end

  // Reset to m1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= ReqM1;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant vector is never more than one-hot.
  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));

endmodule

// File: rtl/hsys_memory_arbiter.sv
// Two-requester single-port memory arbiter with one access per cycle and a
// 1-cycle tagged read-return stage.
module hsys_memory_arbiter
  import hsys_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned BE_W   = DefaultBeW
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       any_grant;
  logic       granted_write;
  req_idx_e   grant_idx;

  logic       rd_valid_q, rd_valid_d;
  req_idx_e   rd_tag_q, rd_tag_d;

  // Requests are masked while reset is held so nothing is granted before the
  // first rising edge with reset released.
  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

  hsys_rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (any_grant),
    .grant   (grant)
  );

  assign any_grant = |grant;
  assign grant_idx = grant_to_idx(grant);

  // Write wins when a requester raises read and write together.
  assign granted_write = (grant[0] & m0_write) | (grant[1] & m1_write);

  assign m0_waitrequest = ~grant[0];
  assign m1_waitrequest = ~grant[1];

  // Memory port follows the granted requester; data fields default to m0.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (grant_idx == ReqM1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
  end

  assign mem_chipselect = any_grant;
  assign mem_write      = granted_write;
  assign mem_clken      = 1'b1;

  // A granted read arms the return stage and records who issued it.
  always_comb begin
    rd_valid_d = any_grant & ~granted_write;
    rd_tag_d   = rd_tag_q;
    if (any_grant && !granted_write) begin
      rd_tag_d = grant_idx;
    end
  end

  // Read-return stage; async reset drops any read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= ReqM0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign m0_readdatavalid = rd_valid_q & (rd_tag_q == ReqM0);
  assign m1_readdatavalid = rd_valid_q & (rd_tag_q == ReqM1);

  // Read data is broadcast; readdatavalid selects the owner.
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

endmodule

// File: tb/tb_hsys_memory_arbiter.sv
// Bench for hsys_memory_arbiter: directed scenarios plus random traffic, with a
// reference model of arbitration and memory contents feeding a read scoreboard.
module tb_hsys_memory_arbiter;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;

  hsys_memory_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    int            req;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_model [1024];
  logic [DW-1:0] ref_mem   [1024];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ref_last = 1;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic acc_t mk_idle();
    acc_t r;
    r = '0;
    return r;
  endfunction

  function automatic acc_t mk_rd(input logic [AW-1:0] a);
    acc_t r;
    r = '0;
    r.rd = 1'b1;
    r.addr = a;
    r.be = '1;
    return r;
  endfunction

  function automatic acc_t mk_wr(input logic [AW-1:0] a, input logic [BW-1:0] be,
                                 input logic [DW-1:0] d);
    acc_t r;
    r = '0;
    r.wr = 1'b1;
    r.addr = a;
    r.be = be;
    r.data = d;
    return r;
  endfunction

  // Behavioural 1024x64 single-port memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      mem_model[mem_address] <= merge(mem_model[mem_address], mem_writedata, mem_byteenable);
    if (mem_chipselect && !mem_write) mem_readdata <= mem_model[mem_address];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One cycle: drive requests after the edge, then at the falling edge compare
  // the combinational grant response with the reference model and update it.
  task automatic do_cycle(input acc_t a0, input acc_t a1);
    int   win;
    acc_t g;
    @(posedge clk);
    #1;
    m0_read = a0.rd; m0_write = a0.wr; m0_address = a0.addr;
    m0_byteenable = a0.be; m0_writedata = a0.data;
    m1_read = a1.rd; m1_write = a1.wr; m1_address = a1.addr;
    m1_byteenable = a1.be; m1_writedata = a1.data;
    @(negedge clk);
    if ((a0.rd || a0.wr) && (a1.rd || a1.wr)) win = (ref_last == 0) ? 1 : 0;
    else if (a0.rd || a0.wr) win = 0;
    else if (a1.rd || a1.wr) win = 1;
    else win = -1;
    g = (win == 1) ? a1 : a0;
    check("m0_waitrequest", m0_waitrequest, (win == 0) ? 1'b0 : 1'b1);
    check("m1_waitrequest", m1_waitrequest, (win == 1) ? 1'b0 : 1'b1);
    check("mem_chipselect", mem_chipselect, (win >= 0) ? 1'b1 : 1'b0);
    check("mem_write", mem_write, (win >= 0 && g.wr) ? 1'b1 : 1'b0);
    check("mem_clken", mem_clken, 1'b1);
    if (win >= 0) begin
      check("mem_address", mem_address, g.addr);
      if (g.wr) begin
        check("mem_writedata", mem_writedata, g.data);
        check("mem_byteenable", mem_byteenable, g.be);
        ref_mem[g.addr] = merge(ref_mem[g.addr], g.data, g.be);
      end else begin
        sb.push_back('{req: win, data: ref_mem[g.addr], due: cyc + 1});
      end
      ref_last = win;
    end
  endtask

  // Assert reset shortly after a falling edge (before the next rising edge),
  // hold it with requests active, and release on a falling edge.
  task automatic do_reset(input int ncyc);
    #1;
    reset_n = 1'b0;
    sb.delete();
    ref_last = 1;
    m0_read = 1'b1; m1_write = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("rst_m0_waitrequest", m0_waitrequest, 1'b1);
      check("rst_m1_waitrequest", m1_waitrequest, 1'b1);
      check("rst_mem_chipselect", mem_chipselect, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
    end
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    reset_n = 1'b1;
  endtask

  // Monitor: compares read-return outputs against the scoreboard every cycle.
  initial begin
    bit exp0, exp1;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        check("rst_m0_readdatavalid", m0_readdatavalid, 1'b0);
        check("rst_m1_readdatavalid", m1_readdatavalid, 1'b0);
      end else begin
        exp0 = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].req == 0);
        exp1 = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].req == 1);
        check("m0_readdatavalid", m0_readdatavalid, exp0);
        check("m1_readdatavalid", m1_readdatavalid, exp1);
        if (exp0) check("m0_readdata", m0_readdata, sb[0].data);
        if (exp1) check("m1_readdata", m1_readdata, sb[0].data);
        if (exp0 || exp1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    acc_t a0, a1;
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = '0;
      ref_mem[i] = '0;
    end
    @(negedge clk);
    do_reset(3);

    // Contention from reset: strict alternation starting with m0.
    for (int i = 0; i < 8; i++) do_cycle(mk_rd(AW'(i)), mk_rd(AW'(i + 8)));

    // Single write then read by m0.
    do_cycle(mk_wr(10'h005, 8'hFF, 64'h0123456789ABCDEF), mk_idle());
    do_cycle(mk_rd(10'h005), mk_idle());
    do_cycle(mk_idle(), mk_idle());

    // Byte lanes on the top address by m1.
    do_cycle(mk_idle(), mk_wr(10'h3FF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF));
    do_cycle(mk_idle(), mk_wr(10'h3FF, 8'h0F, 64'h0));
    do_cycle(mk_idle(), mk_rd(10'h3FF));

    // Write by m0 immediately followed by read of the same word by m1.
    do_cycle(mk_wr(10'h010, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA), mk_idle());
    do_cycle(mk_idle(), mk_rd(10'h010));
    // Same hazard under contention: m0 write then m1 read in consecutive grants.
    do_cycle(mk_wr(10'h011, 8'hFF, 64'h5555_1234_5555_1234), mk_rd(10'h011));
    do_cycle(mk_idle(), mk_rd(10'h011));

    // Reset mid-read: read granted, reset before the next edge.
    do_cycle(mk_rd(10'h005), mk_idle());
    do_reset(2);
    do_cycle(mk_rd(10'h005), mk_rd(10'h3FF));

    // Idle: history must survive, so m1 wins the next contention.
    for (int i = 0; i < 5; i++) do_cycle(mk_idle(), mk_idle());
    do_cycle(mk_rd(10'h010), mk_rd(10'h3FF));

    // Random traffic over a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      int k0, k1;
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      a0 = mk_idle();
      a1 = mk_idle();
      a0.rd = (k0 == 1) || (k0 == 3);
      a0.wr = (k0 >= 2);
      a1.rd = (k1 == 1) || (k1 == 3);
      a1.wr = (k1 >= 2);
      a0.addr = AW'($urandom_range(0, 15));
      a1.addr = AW'($urandom_range(0, 15));
      a0.be = BW'($urandom);
      a1.be = BW'($urandom);
      a0.data = {$urandom, $urandom};
      a1.data = {$urandom, $urandom};
      do_cycle(a0, a1);
    end

    do_cycle(mk_idle(), mk_idle());
    do_cycle(mk_idle(), mk_idle());
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
